// File: rtl/rv_regfile_pkg.sv
//------------------------------------------------------------------------------
// Module  : rv_regfile_pkg
// Purpose : Shared constants and types for the register-file writeback path.
//           Holds the data and index widths, the register count, the register
//           index type and the writeback-source enumeration.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package rv_regfile_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef logic [REG_ADDR_W-1:0] reg_idx_t;

  // Requester index of each writeback source on the arbiter.
  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_LOAD = 2'd1,
    WB_LUI  = 2'd2,
    WB_JAL  = 2'd3
  } wb_src_e;

endpackage : rv_regfile_pkg

`default_nettype wire

// File: rtl/rr_arbiter.sv
//------------------------------------------------------------------------------
// Module  : rr_arbiter
// Purpose : Round-robin arbiter with a registered priority pointer.
//           The search starts at the pointer. After a grant to requester k,
//           the pointer moves to (k+1) mod NUM_REQ. With no grant, it holds.
// Ports   : clk_i     - clock
//           reset_i   - asynchronous active-high reset (pointer -> 0)
//           req_i     - per-requester request
//           advance_i - a grant was accepted this cycle; move the pointer
//           grant_o   - one-hot grant (zero when no request)
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               advance_i,
  output logic [NUM_REQ-1:0] grant_o
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_d;
  logic [PTR_W-1:0] idx;
  logic             found;
  int               pos;
  int               nxt;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // Scan requesters from the pointer position, wrapping modulo NUM_REQ.
  // The first active request wins. If the grant is taken, the pointer moves
  // to the slot just past the winner.
  always_comb begin
    grant_o = '0;
    ptr_d   = ptr_q;
    found   = 1'b0;
    idx     = '0;
    pos     = 0;
    nxt     = 0;
    for (int off = 0; off < NUM_REQ; off++) begin
      pos = int'(ptr_q) + off;
      if (pos >= NUM_REQ) begin
        pos = pos - NUM_REQ;
      end
      idx = PTR_W'(pos);
      if (!found && req_i[idx]) begin
        found        = 1'b1;
        grant_o[idx] = 1'b1;
        nxt          = pos + 1;
        if (nxt >= NUM_REQ) begin
          nxt = 0;
        end
        if (advance_i) begin
          ptr_d = PTR_W'(nxt);
        end
      end
    end
  end

endmodule : rr_arbiter

`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
//------------------------------------------------------------------------------
// Module  : regfile_wb_arbiter
// Purpose : Shares the register file's single write port between the ALU,
//           load, LUI and jump writeback sources. It uses a round-robin
//           arbiter and a registered write stage with one cycle of latency.
//           It also keeps a 32-entry pending-write scoreboard, so issue logic
//           can detect RAW hazards.
// Ports   : clk_i, reset_i        - clock, asynchronous active-high reset
//           req_valid_i/ready_o   - per-requester write handshake
//           req_rd_i, req_data_i  - packed destination/data (slot i at i*W)
//           wr_en_o/addr_o/data_o - registered register-file write port
//           issue_valid_i, issue_rd_i - destination reservation at issue
//           rs1_i, rs2_i, hazard_o    - source hazard query
//           busy_mask_o           - scoreboard contents
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module regfile_wb_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int XLEN       = rv_regfile_pkg::XLEN,
  parameter int REG_ADDR_W = rv_regfile_pkg::REG_ADDR_W
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic [NUM_REQ-1:0]              req_valid_i,
  output logic [NUM_REQ-1:0]              req_ready_o,
  input  logic [NUM_REQ*REG_ADDR_W-1:0]   req_rd_i,
  input  logic [NUM_REQ*XLEN-1:0]         req_data_i,
  output logic                            wr_en_o,
  output logic [REG_ADDR_W-1:0]           wr_addr_o,
  output logic [XLEN-1:0]                 wr_data_o,
  input  logic                            issue_valid_i,
  input  logic [REG_ADDR_W-1:0]           issue_rd_i,
  input  logic [REG_ADDR_W-1:0]           rs1_i,
  input  logic [REG_ADDR_W-1:0]           rs2_i,
  output logic                            hazard_o,
  output logic [rv_regfile_pkg::NUM_REGS-1:0] busy_mask_o
);

  import rv_regfile_pkg::*;

  logic [NUM_REQ-1:0]    arb_grant;
  logic [NUM_REQ-1:0]    grant;
  logic                  hs;
  logic [REG_ADDR_W-1:0] sel_rd;
  logic [XLEN-1:0]       sel_data;

  logic                  wr_en_q,   wr_en_d;
  logic [REG_ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [XLEN-1:0]       wr_data_q, wr_data_d;
  logic [NUM_REGS-1:0]   busy_q,    busy_d;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .req_i     (req_valid_i),
    .advance_i (hs),
    .grant_o   (arb_grant)
  );

  // Ready is combinational. It is forced low while reset is asserted, so no
  // handshake can be counted during reset.
  assign grant       = reset_i ? '0 : arb_grant;
  assign req_ready_o = grant;
  assign hs          = |grant;

  // The grant is one-hot, so an OR-mux is enough to pick the winner's payload.
  always_comb begin
    sel_rd   = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_rd   = sel_rd   | req_rd_i[i*REG_ADDR_W +: REG_ADDR_W];
        sel_data = sel_data | req_data_i[i*XLEN +: XLEN];
      end
    end
  end

  // Output stage. A write to x0 completes the handshake but never raises
  // wr_en. Address and data hold between writes.
  always_comb begin
    wr_en_d   = hs && (sel_rd != '0);
    wr_addr_d = hs ? sel_rd   : wr_addr_q;
    wr_data_d = hs ? sel_data : wr_data_q;
  end

  // Scoreboard. The outgoing write clears its bit, and a same-cycle issue to
  // the same register sets it again. The newer producer owns the register, so
  // set takes priority. Bit 0 never holds a reservation.
  always_comb begin
    busy_d = busy_q;
    if (wr_en_q) begin
      busy_d[wr_addr_q] = 1'b0;
    end
    if (issue_valid_i && (issue_rd_i != '0)) begin
      busy_d[issue_rd_i] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= '0;
    end else begin
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
    end
  end

  assign wr_en_o     = wr_en_q;
  assign wr_addr_o   = wr_addr_q;
  assign wr_data_o   = wr_data_q;
  assign busy_mask_o = busy_q;

  // No bypass: a source whose producer is still pending reports a hazard.
  assign hazard_o = ((rs1_i != '0) && busy_q[rs1_i]) ||
                    ((rs2_i != '0) && busy_q[rs2_i]);

endmodule : regfile_wb_arbiter

`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
//------------------------------------------------------------------------------
// Module  : tb_regfile_wb_arbiter
// Purpose : Self-checking bench for regfile_wb_arbiter. Stimulus issues the
//           requests, and a reference model predicts grants, the scoreboard
//           and hazards. Expected writes are queued, and a separate monitor
//           checks them as they appear on the write port.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_regfile_wb_arbiter;

  localparam int N  = 4;
  localparam int XL = 32;
  localparam int AW = 5;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*AW-1:0] req_rd;
  logic [N*XL-1:0] req_data;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [XL-1:0]   wr_data;
  logic            issue_valid;
  logic [AW-1:0]   issue_rd;
  logic [AW-1:0]   rs1;
  logic [AW-1:0]   rs2;
  logic            hazard;
  logic [31:0]     busy_mask;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(
    .NUM_REQ    (N),
    .XLEN       (XL),
    .REG_ADDR_W (AW)
  ) dut (
    .clk_i         (clk),
    .reset_i       (reset),
    .req_valid_i   (req_valid),
    .req_ready_o   (req_ready),
    .req_rd_i      (req_rd),
    .req_data_i    (req_data),
    .wr_en_o       (wr_en),
    .wr_addr_o     (wr_addr),
    .wr_data_o     (wr_data),
    .issue_valid_i (issue_valid),
    .issue_rd_i    (issue_rd),
    .rs1_i         (rs1),
    .rs2_i         (rs2),
    .hazard_o      (hazard),
    .busy_mask_o   (busy_mask)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Expected register-file writes, in the order they must appear: {rd, data}.
  logic [AW+XL-1:0] exp_q[$];

  // Reference model state.
  int        m_ptr      = 0;  // next requester with priority
  bit [31:0] m_busy     = '0; // registers with a pending write
  int        m_prev_rd  = 0;  // rd written out in the coming cycle (0 = none)
  int        last_grant = -1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] rd, input logic [XL-1:0] data);
    req_valid[i]          = 1'b1;
    req_rd[i*AW +: AW]    = rd;
    req_data[i*XL +: XL]  = data;
  endtask

  task automatic model_reset();
    m_ptr      = 0;
    m_busy     = '0;
    m_prev_rd  = 0;
    last_grant = -1;
    exp_q.delete();
  endtask

  // Called at a falling edge, after the inputs for this cycle are applied.
  // It checks the combinational outputs against the model, advances the
  // model across the next rising edge, and returns at the next falling edge.
  task automatic step();
    int            g;
    logic [N-1:0]  exp_ready;
    logic          exp_haz;
    logic [AW-1:0] rd;
    #1;
    g = -1;
    for (int o = 0; o < N; o++) begin
      if (g < 0 && req_valid[(m_ptr + o) % N]) g = (m_ptr + o) % N;
    end
    exp_ready = (g >= 0) ? N'(1 << g) : '0;
    exp_haz   = (rs1 != 0 && m_busy[rs1]) || (rs2 != 0 && m_busy[rs2]);
    chk("req_ready", 64'(req_ready), 64'(exp_ready));
    chk("hazard",    64'(hazard),    64'(exp_haz));
    chk("busy_mask", 64'(busy_mask), 64'(m_busy));
    if (m_prev_rd != 0) m_busy[m_prev_rd] = 1'b0;
    if (issue_valid && issue_rd != 0) m_busy[issue_rd] = 1'b1;
    m_prev_rd  = 0;
    last_grant = g;
    if (g >= 0) begin
      rd        = req_rd[g*AW +: AW];
      m_ptr     = (g + 1) % N;
      m_prev_rd = int'(rd);
      if (rd != 0) exp_q.push_back({rd, req_data[g*XL +: XL]});
    end
    @(negedge clk);
  endtask

  task automatic retire();
    if (last_grant >= 0) req_valid[last_grant] = 1'b0;
  endtask

  // Write-port monitor: each write must match the oldest expected entry. An
  // expected entry with no write one cycle after its grant is a missing write.
  initial begin
    logic [AW+XL-1:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (wr_en === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected no write at %0t",
                   wr_addr, wr_data, $time);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", 64'(wr_addr), 64'(e[XL +: AW]));
          chk("wr_data", 64'(wr_data), 64'(e[XL-1:0]));
        end
      end else if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("wr_en", 64'(wr_en), 64'd1);
      end
    end
  end

  initial begin
    reset       = 1'b1;
    req_valid   = '0;
    req_rd      = '0;
    req_data    = '0;
    issue_valid = 1'b0;
    issue_rd    = '0;
    rs1         = '0;
    rs2         = '0;
    repeat (2) @(negedge clk);
    req_valid = '1;
    #1;
    chk("rst_wr_en",     64'(wr_en),     64'd0);
    chk("rst_wr_addr",   64'(wr_addr),   64'd0);
    chk("rst_wr_data",   64'(wr_data),   64'd0);
    chk("rst_busy",      64'(busy_mask), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    reset     = 1'b0;
    req_valid = '0;
    model_reset();

    // Single ALU write to r5.
    set_req(0, 5'd5, 32'h0000_0005);
    step();
    retire();
    step();

    // All four requesters continuously valid with distinct rd.
    for (int i = 0; i < N; i++) set_req(i, AW'(i + 1), 32'h100 + 32'(i));
    repeat (8) begin
      step();
      set_req(last_grant, AW'(last_grant + 1), 32'h200 + 32'($urandom_range(255)));
    end
    req_valid = '0;
    step();

    // Reserve r8, observe the hazard, then let the load write r8.
    issue_valid = 1'b1;
    issue_rd    = 5'd8;
    step();
    issue_valid = 1'b0;
    rs1         = 5'd8;
    step();
    set_req(1, 5'd8, 32'hC);
    step();
    retire();
    repeat (3) step();

    // Reissue r6 in the same cycle that a write to r6 is on the port.
    set_req(0, 5'd6, 32'h66);
    step();
    retire();
    issue_valid = 1'b1;
    issue_rd    = 5'd6;
    step();
    issue_valid = 1'b0;
    rs2         = 5'd6;
    step();

    // Jump with rd=0: handshake completes, no write, no hazard.
    set_req(3, 5'd0, 32'h40);
    rs1 = 5'd0;
    rs2 = 5'd0;
    step();
    retire();
    step();

    // Reset mid-stream: a write is on the port and another grant is pending.
    issue_valid = 1'b1;
    issue_rd    = 5'd12;
    set_req(1, 5'd7, 32'h77);
    step();
    retire();
    issue_valid = 1'b0;
    set_req(2, 5'd10, 32'hAA);
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_wr_en",     64'(wr_en),     64'd0);
    chk("midrst_busy",      64'(busy_mask), 64'd0);
    chk("midrst_req_ready", 64'(req_ready), 64'd0);
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < N; i++) set_req(i, AW'(i + 1), 32'h300 + 32'(i));
    step();
    chk("first_grant_after_reset", 64'(last_grant), 64'd0);

    // Randomised traffic.
    repeat (2000) begin
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && last_grant == i) begin
          req_valid[i] = 1'b0;
        end else if (req_valid[i] && $urandom_range(15) == 0) begin
          req_valid[i] = 1'b0;
        end else if (!req_valid[i] && $urandom_range(2) == 0) begin
          set_req(i, ($urandom_range(7) == 0) ? AW'(0) : AW'($urandom_range(1, 9)), $urandom);
        end
      end
      issue_valid = ($urandom_range(2) == 0);
      issue_rd    = AW'($urandom_range(9));
      rs1         = AW'($urandom_range(9));
      rs2         = AW'($urandom_range(9));
      step();
    end

    req_valid   = '0;
    issue_valid = 1'b0;
    repeat (2) step();
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_regfile_wb_arbiter

`default_nettype wire
